disk_flip_sequencer: RTL
========================

DISK_FLIP_SEQUENCER -- requirements
Module: disk_flip_sequencer

Interface
REQ-001 Parameter EMPTY_CHECK, default 1: when 1, placement on an occupied origin is rejected without scanning.
REQ-002 clk  input  1  system clock, all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to evaluate and apply a placement.
REQ-005 x, y  input  3 each  origin column/row, sampled on accepted start.
REQ-006 side  input  1  mover, sampled on start: 0 = black (cell code 01), 1 = white (cell code 10).
REQ-007 rd_addr  output  6  board RAM read address, y*8+x.
REQ-008 rd_data  input  2  board RAM read data, valid one cycle after rd_addr (synchronous RAM).
REQ-009 wr_en, wr_addr, wr_data  output  1/6/2  board RAM write port.
REQ-010 draw_req, draw_x, draw_y, draw_color  output  1/3/3/2  cell redraw request to the drawing datapath.
REQ-011 draw_ack  input  1  drawer accepts the request in any cycle where draw_req and draw_ack are both high.
REQ-012 busy  output  1  high from the cycle after an accepted start until done.
REQ-013 done  output  1  one-cycle pulse at the end of every accepted request.
REQ-014 legal, flip_count  output  1/6  result of the last request, valid from done until the next accepted start.

Function
REQ-015 Cell codes: 00 empty, 01 black, 10 white; 11 is treated as empty.
REQ-016 start is accepted only in IDLE; start while busy is ignored.
REQ-017 States: IDLE, CHK_ORIGIN, SCAN_RD, SCAN_EVAL, FLIP_WR, FLIP_DRAW, NEXT_DIR, PLACE_WR, PLACE_DRAW, FINISH.
REQ-018 CHK_ORIGIN reads the origin; when EMPTY_CHECK=1 and the cell is non-empty, the FSM goes to FINISH with legal=0 and flip_count=0, and performs no writes.
REQ-019 Directions are scanned in fixed order 0..7 as (dx,dy): (0,-1),(1,-1),(1,0),(1,1),(0,1),(-1,1),(-1,0),(-1,-1).
REQ-020 In SCAN_RD the block issues a read at origin+(k+1)*(dx,dy), where k is the run length so far; SCAN_EVAL evaluates rd_data the following cycle.
REQ-021 Coordinates are 4-bit signed internally; a step outside 0..7 on either axis ends the direction with no flips (no row/column wrap).
REQ-022 Opponent cell: run increments and scanning continues. Empty cell: direction ends, no flips. Own cell with run=0: no flips. Own cell with run>0: enter FLIP_WR.
REQ-023 FLIP_WR writes the own code to each of the run cells, nearest to origin first, one write per visit; after each write, FLIP_DRAW holds draw_req with that cell's coordinates and own colour until draw_ack; then the next cell is processed or NEXT_DIR is entered.
REQ-024 draw_x, draw_y and draw_color are stable while draw_req is high; no RAM write occurs while draw_req is high.
REQ-025 flip_count accumulates all flipped cells across directions, saturating at 63.
REQ-026 After direction 7: if flip_count>0, PLACE_WR writes the own code at the origin, PLACE_DRAW issues its redraw handshake, and legal=1; otherwise legal=0 with no origin write.
REQ-027 FINISH asserts done for one cycle, deasserts busy, and returns to IDLE.
REQ-028 wr_en is high for exactly one cycle per write; it is never high in IDLE, CHK_ORIGIN, SCAN_* or FINISH.

Reset
REQ-029 While reset_n is low: state IDLE; busy, done, wr_en, draw_req, legal are 0; flip_count, rd_addr, wr_addr, wr_data, draw_x, draw_y, draw_color are 0.
REQ-030 Reset asserted mid-operation aborts immediately; writes already made are kept and no further write or draw_req is issued.

Verification
REQ-031 Opening board (3,3)=10, (4,4)=10, (3,4)=01, (4,3)=01; start with side=0, x=3, y=2 -> one write addr 27 data 01, then addr 19 data 01; legal=1, flip_count=1.
REQ-032 Same board; start with side=0 at (0,0) -> no wr_en, draw_req never high; done with legal=0, flip_count=0.
REQ-033 start with side=0 at occupied (3,3) and EMPTY_CHECK=1 -> done within 4 cycles, legal=0, no writes.
REQ-034 Row 0 with x=1..7 set to 10 and (0,1)=01; black at (0,0) -> E direction reaches the edge, no flips, no write to addr 8; legal=0.
REQ-035 Hold draw_ack low for 5 cycles during the first flip -> draw_req stays high with constant coordinates and no further wr_en; completes normally after the ack.
REQ-036 Assert reset_n low during FLIP_DRAW -> all outputs are 0 on assertion; after release the block is IDLE and accepts a new start.

Source files
------------

// File: rtl/disk_flip_sequencer.sv
// Placement sequencer for an 8x8 disc-flipping board: scans eight directions through a
// synchronous board RAM, rewrites captured runs and hands each changed cell to the drawer.
module disk_flip_sequencer #(
    parameter int unsigned EMPTY_CHECK = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic       side,
    output logic [5:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic [1:0] wr_data,
    output logic       draw_req,
    output logic [2:0] draw_x,
    output logic [2:0] draw_y,
    output logic [1:0] draw_color,
    input  logic       draw_ack,
    output logic       busy,
    output logic       done,
    output logic       legal,
    output logic [5:0] flip_count
);

    typedef enum logic [3:0] {
        StIdle, StChkOrigin, StScanRd, StScanEval, StFlipWr,
        StFlipDraw, StNextDir, StPlaceWr, StPlaceDraw, StFinish
    } state_e;

    state_e             r_state, w_state_next;
    logic [2:0]         r_ox, r_oy, w_ox_next, w_oy_next;
    logic               r_side, w_side_next;
    logic               r_chk_rd, w_chk_rd_next;
    logic [2:0]         r_dir, w_dir_next;
    logic [2:0]         r_run, w_run_next;
    logic signed [3:0]  r_px, r_py, w_px_next, w_py_next;
    logic [5:0]         r_cnt, w_cnt_next;
    logic               r_legal, w_legal_next;

    logic signed [3:0]  w_dx, w_dy, w_nx, w_ny, w_ox_s, w_oy_s;
    logic [1:0]         w_own, w_opp;
    logic               w_in;
    logic [5:0]         w_org_addr;

    always_comb begin
        unique case (r_dir)
            3'd0:    begin w_dx =  4'sd0; w_dy = -4'sd1; end
            3'd1:    begin w_dx =  4'sd1; w_dy = -4'sd1; end
            3'd2:    begin w_dx =  4'sd1; w_dy =  4'sd0; end
            3'd3:    begin w_dx =  4'sd1; w_dy =  4'sd1; end
            3'd4:    begin w_dx =  4'sd0; w_dy =  4'sd1; end
            3'd5:    begin w_dx = -4'sd1; w_dy =  4'sd1; end
            3'd6:    begin w_dx = -4'sd1; w_dy =  4'sd0; end
            default: begin w_dx = -4'sd1; w_dy = -4'sd1; end
        endcase
    end

    // One step past either edge lands on -1 or 8 (wraps to -8); both set bit 3.
    assign w_nx       = r_px + w_dx;
    assign w_ny       = r_py + w_dy;
    assign w_in       = ~w_nx[3] & ~w_ny[3];
    assign w_own      = r_side ? 2'b10 : 2'b01;
    assign w_opp      = r_side ? 2'b01 : 2'b10;
    assign w_org_addr = {r_oy, r_ox};
    assign w_ox_s     = signed'({1'b0, r_ox});
    assign w_oy_s     = signed'({1'b0, r_oy});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= StIdle;
            r_ox     <= '0;
            r_oy     <= '0;
            r_side   <= 1'b0;
            r_chk_rd <= 1'b0;
            r_dir    <= '0;
            r_run    <= '0;
            r_px     <= '0;
            r_py     <= '0;
            r_cnt    <= '0;
            r_legal  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ox     <= w_ox_next;
            r_oy     <= w_oy_next;
            r_side   <= w_side_next;
            r_chk_rd <= w_chk_rd_next;
            r_dir    <= w_dir_next;
            r_run    <= w_run_next;
            r_px     <= w_px_next;
            r_py     <= w_py_next;
            r_cnt    <= w_cnt_next;
            r_legal  <= w_legal_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_ox_next     = r_ox;
        w_oy_next     = r_oy;
        w_side_next   = r_side;
        w_chk_rd_next = r_chk_rd;
        w_dir_next    = r_dir;
        w_run_next    = r_run;
        w_px_next     = r_px;
        w_py_next     = r_py;
        w_cnt_next    = r_cnt;
        w_legal_next  = r_legal;
        rd_addr       = '0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        draw_req      = 1'b0;
        draw_x        = '0;
        draw_y        = '0;
        draw_color    = '0;
        done          = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next  = StChkOrigin;
                    w_ox_next     = x;
                    w_oy_next     = y;
                    w_side_next   = side;
                    w_chk_rd_next = 1'b0;
                    w_cnt_next    = '0;
                    w_legal_next  = 1'b0;
                end
            end
            StChkOrigin: begin
                // First cycle issues the origin read, second cycle sees its data.
                if (!r_chk_rd) begin
                    rd_addr       = w_org_addr;
                    w_chk_rd_next = 1'b1;
                end else if (EMPTY_CHECK != 0 && (rd_data == 2'b01 || rd_data == 2'b10)) begin
                    w_state_next = StFinish;
                end else begin
                    w_state_next = StScanRd;
                    w_dir_next   = '0;
                    w_run_next   = '0;
                    w_px_next    = w_ox_s;
                    w_py_next    = w_oy_s;
                end
            end
            StScanRd: begin
                if (w_in) begin
                    rd_addr      = {w_ny[2:0], w_nx[2:0]};
                    w_px_next    = w_nx;
                    w_py_next    = w_ny;
                    w_state_next = StScanEval;
                end else begin
                    w_state_next = StNextDir;
                end
            end
            StScanEval: begin
                if (rd_data == w_opp) begin
                    w_run_next   = r_run + 3'd1;
                    w_state_next = StScanRd;
                end else if (rd_data == w_own && r_run != 3'd0) begin
                    w_px_next    = w_ox_s;
                    w_py_next    = w_oy_s;
                    w_state_next = StFlipWr;
                end else begin
                    w_state_next = StNextDir;
                end
            end
            StFlipWr: begin
                wr_en        = 1'b1;
                wr_addr      = {w_ny[2:0], w_nx[2:0]};
                wr_data      = w_own;
                w_px_next    = w_nx;
                w_py_next    = w_ny;
                w_run_next   = r_run - 3'd1;
                w_cnt_next   = (r_cnt == 6'd63) ? r_cnt : r_cnt + 6'd1;
                w_state_next = StFlipDraw;
            end
            StFlipDraw: begin
                draw_req   = 1'b1;
                draw_x     = r_px[2:0];
                draw_y     = r_py[2:0];
                draw_color = w_own;
                if (draw_ack) w_state_next = (r_run == 3'd0) ? StNextDir : StFlipWr;
            end
            StNextDir: begin
                if (r_dir == 3'd7) begin
                    w_state_next = (r_cnt != 6'd0) ? StPlaceWr : StFinish;
                end else begin
                    w_dir_next   = r_dir + 3'd1;
                    w_run_next   = '0;
                    w_px_next    = w_ox_s;
                    w_py_next    = w_oy_s;
                    w_state_next = StScanRd;
                end
            end
            StPlaceWr: begin
                wr_en        = 1'b1;
                wr_addr      = w_org_addr;
                wr_data      = w_own;
                w_state_next = StPlaceDraw;
            end
            StPlaceDraw: begin
                draw_req   = 1'b1;
                draw_x     = r_ox;
                draw_y     = r_oy;
                draw_color = w_own;
                if (draw_ack) begin
                    w_legal_next = 1'b1;
                    w_state_next = StFinish;
                end
            end
            StFinish: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign busy       = (r_state != StIdle) && (r_state != StFinish);
    assign legal      = r_legal;
    assign flip_count = r_cnt;

endmodule
